// File: rtl/mem_stage_pkg.sv
// Shared encodings and helpers for the parametrised MEM stage.
// Size codes, FSM state type and load lane-extension mux.
package mem_stage_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_WAIT = 1'b1;

  // Shift the addressed lane down, then sign/zero extend by size.
  function automatic logic [63:0] lane_ext(
    input logic [63:0] row,
    input logic [2:0]  lane,
    input logic [1:0]  size,
    input logic        uns
  );
    logic [63:0] s;
    s = row >> {lane, 3'b000};
    unique case (size)
      SIZE_B:  lane_ext = {{56{s[7] & ~uns}}, s[7:0]};
      SIZE_H:  lane_ext = {{48{s[15] & ~uns}}, s[15:0]};
      SIZE_W:  lane_ext = {{32{s[31] & ~uns}}, s[31:0]};
      default: lane_ext = s;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_dmem.sv
// Byte-lane data RAM with per-lane write enables.
// Read data passes through LOAD_LAT-1 output registers.
module mem_stage_dmem
  import mem_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int LOAD_LAT = 1
) (
  input  logic                                   clk,
  input  logic [ADDR_W-$clog2(DATA_W/8)-1:0]     row,
  input  logic [DATA_W/8-1:0]                    be,
  input  logic [DATA_W-1:0]                      wdata,
  output logic [DATA_W-1:0]                      rdata
);

  localparam int NB   = DATA_W / 8;
  localparam int ROWS = 2 ** (ADDR_W - $clog2(NB));

  logic [DATA_W-1:0] mem [ROWS];
  logic [DATA_W-1:0] rd0;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (be[i]) mem[row][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  assign rd0 = mem[row];

  generate
    if (LOAD_LAT == 1) begin : g_comb
      assign rdata = rd0;
    end else begin : g_pipe
      logic [DATA_W-1:0] pipe [LOAD_LAT-1];
      always_ff @(posedge clk) begin
        pipe[0] <= rd0;
        for (int i = 1; i < LOAD_LAT - 1; i++) pipe[i] <= pipe[i-1];
      end
      assign rdata = pipe[LOAD_LAT-2];
    end
  endgenerate

endmodule

// File: rtl/mem_stage_param.sv
// Parametrised MEM stage: sub-word loads/stores, misalign trap,
// multi-cycle load with stall, store-data forwarding from MEM/WB.
module mem_stage_param
  import mem_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_rt_reg,
  input  logic [REG_W-1:0]  ex_write_reg,
  output logic              mem_stall,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [REG_W-1:0]  wb_write_reg,
  output logic              wb_misaligned
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);

  logic [ADDR_W-1:0] addr;
  logic [2:0]        lane;
  logic              is_load, is_store, mis, idle;
  logic              start_wait, fwd_hit;
  logic [DATA_W-1:0] sdata, wdata, rdata, ld_now, ld_pend;
  logic [7:0]        be_base, be_sh;
  logic [NB-1:0]     be;
  state_t            state;
  logic [2:0]        cnt;

  logic [DATA_W-1:0] p_alu;
  logic [REG_W-1:0]  p_wreg;
  logic              p_rw, p_m2r, p_uns;
  logic [1:0]        p_size;
  logic [2:0]        p_lane;

  assign addr     = ex_alu_result[ADDR_W-1:0];
  assign lane     = 3'(addr[LB-1:0]);
  assign is_store = ex_mem_write;
  assign is_load  = ex_mem_read & ~ex_mem_write;
  assign idle     = (state == ST_IDLE);

  always_comb begin
    mis     = 1'b0;
    be_base = 8'h00;
    unique case (ex_size)
      SIZE_B: begin mis = 1'b0;       be_base = 8'h01; end
      SIZE_H: begin mis = addr[0];    be_base = 8'h03; end
      SIZE_W: begin mis = |addr[1:0]; be_base = 8'h0F; end
      default: begin
        mis     = (DATA_W == 32) | (|addr[2:0]);
        be_base = 8'hFF;
      end
    endcase
    mis = mis & (is_load | is_store);
  end

  assign fwd_hit = wb_valid & wb_reg_write
                 & (wb_write_reg == ex_rt_reg)
                 & (ex_rt_reg != '0);
  assign sdata = fwd_hit
               ? (wb_mem_to_reg ? wb_read_data : wb_alu_result)
               : ex_store_data;
  assign wdata = sdata << {lane, 3'b000};
  assign be_sh = be_base << lane;
  assign be    = (idle & ex_valid & is_store & ~mis) ? be_sh[NB-1:0] : '0;

  assign start_wait = (LOAD_LAT > 1) & idle & ex_valid & is_load & ~mis;
  assign mem_stall  = start_wait | (state == ST_WAIT);

  mem_stage_dmem #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .LOAD_LAT (LOAD_LAT)
  ) u_dmem (
    .clk   (clk),
    .row   (addr[ADDR_W-1:LB]),
    .be    (be),
    .wdata (wdata),
    .rdata (rdata)
  );

  assign ld_now  = DATA_W'(lane_ext(64'(rdata), lane, ex_size, ex_unsigned));
  assign ld_pend = DATA_W'(lane_ext(64'(rdata), p_lane, p_size, p_uns));

  // WB regs default to a bubble; the branches below override it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_alu_result <= '0;
      wb_read_data  <= '0;
      wb_write_reg  <= '0;
      wb_misaligned <= 1'b0;
      p_alu         <= '0;
      p_wreg        <= '0;
      p_rw          <= 1'b0;
      p_m2r         <= 1'b0;
      p_uns         <= 1'b0;
      p_size        <= '0;
      p_lane        <= '0;
    end else begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_alu_result <= '0;
      wb_read_data  <= '0;
      wb_write_reg  <= '0;
      wb_misaligned <= 1'b0;
      if (state == ST_WAIT) begin
        cnt <= cnt - 3'd1;
        if (cnt == 3'd1) begin
          state         <= ST_IDLE;
          wb_valid      <= 1'b1;
          wb_reg_write  <= p_rw;
          wb_mem_to_reg <= p_m2r;
          wb_alu_result <= p_alu;
          wb_read_data  <= ld_pend;
          wb_write_reg  <= p_wreg;
        end
      end else if (start_wait) begin
        state  <= ST_WAIT;
        cnt    <= 3'(LOAD_LAT - 1);
        p_alu  <= ex_alu_result;
        p_wreg <= ex_write_reg;
        p_rw   <= ex_reg_write;
        p_m2r  <= ex_mem_to_reg;
        p_uns  <= ex_unsigned;
        p_size <= ex_size;
        p_lane <= lane;
      end else if (ex_valid) begin
        wb_valid      <= 1'b1;
        wb_reg_write  <= ex_reg_write & ~mis;
        wb_mem_to_reg <= ex_mem_to_reg;
        wb_alu_result <= ex_alu_result;
        wb_read_data  <= (is_load & ~mis) ? ld_now : '0;
        wb_write_reg  <= ex_write_reg;
        wb_misaligned <= mis;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_param.sv
// Bench for mem_stage_param: 32-bit single-cycle instance and
// 64-bit three-cycle-load instance, checked via scoreboards.
module tb_mem_stage_param;

  localparam int LAT_B = 3;
  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;
  localparam logic [1:0] SD = 2'b11;

  typedef struct packed {
    logic [63:0] alu;
    logic [63:0] rd;
    logic [4:0]  wreg;
    logic        rw;
    logic        m2r;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   nerr = 0;
  int   nchk = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  always #5 clk = ~clk;

  logic        a_valid, a_rw, a_m2r, a_rd, a_wr, a_uns;
  logic [1:0]  a_size;
  logic [31:0] a_alu, a_sd;
  logic [4:0]  a_rt, a_wreg;
  logic        a_stall, a_wbv, a_wrw, a_wm2r, a_wmis;
  logic [31:0] a_walu, a_wrd;
  logic [4:0]  a_wwreg;

  logic        b_valid, b_rw, b_m2r, b_rd, b_wr, b_uns;
  logic [1:0]  b_size;
  logic [63:0] b_alu, b_sd;
  logic [4:0]  b_rt, b_wreg;
  logic        b_stall, b_wbv, b_wrw, b_wm2r, b_wmis;
  logic [63:0] b_walu, b_wrd;
  logic [4:0]  b_wwreg;

  mem_stage_param #(
    .DATA_W(32), .ADDR_W(10), .REG_W(5), .LOAD_LAT(1)
  ) u_a (
    .clk(clk), .rst(rst),
    .ex_valid(a_valid), .ex_reg_write(a_rw),
    .ex_mem_to_reg(a_m2r), .ex_mem_read(a_rd),
    .ex_mem_write(a_wr), .ex_size(a_size),
    .ex_unsigned(a_uns), .ex_alu_result(a_alu),
    .ex_store_data(a_sd), .ex_rt_reg(a_rt),
    .ex_write_reg(a_wreg), .mem_stall(a_stall),
    .wb_valid(a_wbv), .wb_reg_write(a_wrw),
    .wb_mem_to_reg(a_wm2r), .wb_alu_result(a_walu),
    .wb_read_data(a_wrd), .wb_write_reg(a_wwreg),
    .wb_misaligned(a_wmis)
  );

  mem_stage_param #(
    .DATA_W(64), .ADDR_W(10), .REG_W(5), .LOAD_LAT(LAT_B)
  ) u_b (
    .clk(clk), .rst(rst),
    .ex_valid(b_valid), .ex_reg_write(b_rw),
    .ex_mem_to_reg(b_m2r), .ex_mem_read(b_rd),
    .ex_mem_write(b_wr), .ex_size(b_size),
    .ex_unsigned(b_uns), .ex_alu_result(b_alu),
    .ex_store_data(b_sd), .ex_rt_reg(b_rt),
    .ex_write_reg(b_wreg), .mem_stall(b_stall),
    .wb_valid(b_wbv), .wb_reg_write(b_wrw),
    .wb_mem_to_reg(b_wm2r), .wb_alu_result(b_walu),
    .wb_read_data(b_wrd), .wb_write_reg(b_wwreg),
    .wb_misaligned(b_wmis)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drv_a(input logic rd, input logic wr,
                       input logic rw, input logic m2r,
                       input logic [1:0] sz, input logic un,
                       input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] rt, input logic [4:0] wreg,
                       input logic [31:0] erd, input logic mis);
    exp_t e;
    a_valid = 1'b1; a_rd = rd; a_wr = wr; a_rw = rw; a_m2r = m2r;
    a_size = sz; a_uns = un; a_alu = alu; a_sd = sd;
    a_rt = rt; a_wreg = wreg;
    e = '{alu: 64'(alu), rd: 64'(erd), wreg: wreg,
          rw: rw & ~mis, m2r: m2r, mis: mis};
    qa.push_back(e);
    @(negedge clk);
    chk("a_stall", 64'(a_stall), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic sw_a(input logic [1:0] sz, input logic [31:0] ad,
                      input logic [31:0] d, input logic [4:0] rt,
                      input logic mis);
    drv_a(1'b0, 1'b1, 1'b0, 1'b0, sz, 1'b0, ad, d, rt, 5'd0, 32'd0, mis);
  endtask

  task automatic ld_a(input logic [1:0] sz, input logic un,
                      input logic [31:0] ad, input logic [4:0] wreg,
                      input logic [31:0] exp, input logic mis);
    drv_a(1'b1, 1'b0, 1'b1, 1'b1, sz, un, ad, 32'd0, 5'd0, wreg,
          exp, mis);
  endtask

  task automatic alu_a(input logic [31:0] v, input logic [4:0] wreg);
    drv_a(1'b0, 1'b0, 1'b1, 1'b0, SW, 1'b0, v, 32'd0, 5'd0, wreg,
          32'd0, 1'b0);
  endtask

  task automatic drv_b(input logic rd, input logic wr,
                       input logic [1:0] sz, input logic un,
                       input logic [63:0] alu, input logic [63:0] sd,
                       input logic [4:0] wreg,
                       input logic [63:0] erd, input logic mis);
    exp_t e;
    b_valid = 1'b1; b_rd = rd; b_wr = wr; b_rw = rd; b_m2r = rd;
    b_size = sz; b_uns = un; b_alu = alu; b_sd = sd;
    b_rt = 5'd0; b_wreg = wreg;
    e = '{alu: alu, rd: erd, wreg: wreg,
          rw: rd & ~mis, m2r: rd, mis: mis};
    qb.push_back(e);
    if (rd & ~wr & ~mis) begin
      for (int k = 0; k < LAT_B; k++) begin
        @(negedge clk);
        chk("b_stall", 64'(b_stall), 64'd1);
        if (k > 0) chk("b_bubble", 64'(b_wbv), 64'd0);
        @(posedge clk); #1;
      end
    end else begin
      @(negedge clk);
      chk("b_nostall", 64'(b_stall), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_a();
    a_valid = 1'b0; a_rd = 1'b0; a_wr = 1'b0; a_rw = 1'b0;
    a_m2r = 1'b0; a_size = SB; a_uns = 1'b0; a_alu = '0;
    a_sd = '0; a_rt = '0; a_wreg = '0;
  endtask

  task automatic idle_b();
    b_valid = 1'b0; b_rd = 1'b0; b_wr = 1'b0; b_rw = 1'b0;
    b_m2r = 1'b0; b_size = SB; b_uns = 1'b0; b_alu = '0;
    b_sd = '0; b_rt = '0; b_wreg = '0;
  endtask

  always @(negedge clk) begin
    if (!rst && a_wbv) begin
      if (qa.size() == 0) chk("a_extra", 64'd1, 64'd0);
      else begin
        ea = qa.pop_front();
        chk("a_rdata", 64'(a_wrd), ea.rd);
        chk("a_alu", 64'(a_walu), ea.alu);
        chk("a_ctl", {56'd0, a_wrw, a_wm2r, a_wmis, a_wwreg},
            {56'd0, ea.rw, ea.m2r, ea.mis, ea.wreg});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_wbv) begin
      if (qb.size() == 0) chk("b_extra", 64'd1, 64'd0);
      else begin
        eb = qb.pop_front();
        chk("b_rdata", b_wrd, eb.rd);
        chk("b_alu", b_walu, eb.alu);
        chk("b_ctl", {56'd0, b_wrw, b_wm2r, b_wmis, b_wwreg},
            {56'd0, eb.rw, eb.m2r, eb.mis, eb.wreg});
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle_a();
    idle_b();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_wbv", 64'(a_wbv), 64'd0);
    chk("rst_a_alu", 64'(a_walu), 64'd0);
    chk("rst_a_stall", 64'(a_stall), 64'd0);
    chk("rst_b_wbv", 64'(b_wbv), 64'd0);
    chk("rst_b_rd", b_wrd, 64'd0);
    chk("rst_b_stall", 64'(b_stall), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    sw_a(SW, 32'h08, 32'h11111111, 5'd0, 1'b0);
    sw_a(SW, 32'h09, 32'h01010101, 5'd0, 1'b1);
    ld_a(SW, 1'b0, 32'h08, 5'd1, 32'h11111111, 1'b0);
    sw_a(SW, 32'h08, 32'h01010101, 5'd0, 1'b0);
    ld_a(SW, 1'b0, 32'h08, 5'd1, 32'h01010101, 1'b0);
    sw_a(SB, 32'h0B, 32'h000000FF, 5'd0, 1'b0);
    ld_a(SB, 1'b0, 32'h0B, 5'd2, 32'hFFFFFFFF, 1'b0);
    ld_a(SB, 1'b1, 32'h0B, 5'd2, 32'h000000FF, 1'b0);
    ld_a(SH, 1'b0, 32'h0A, 5'd3, 32'hFFFFFF01, 1'b0);
    ld_a(SH, 1'b1, 32'h0A, 5'd3, 32'h0000FF01, 1'b0);
    ld_a(SH, 1'b0, 32'h09, 5'd3, 32'h0, 1'b1);
    ld_a(SD, 1'b0, 32'h08, 5'd4, 32'h0, 1'b1);
    sw_a(SD, 32'h08, 32'h0, 5'd0, 1'b1);
    ld_a(SW, 1'b0, 32'h08, 5'd4, 32'hFF010101, 1'b0);

    sw_a(SW, 32'h30, 32'hCAFEBABE, 5'd0, 1'b0);
    ld_a(SW, 1'b0, 32'h30, 5'd5, 32'hCAFEBABE, 1'b0);
    sw_a(SW, 32'h10, 32'h0, 5'd5, 1'b0);
    ld_a(SW, 1'b0, 32'h10, 5'd6, 32'hCAFEBABE, 1'b0);
    alu_a(32'h55AA0000, 5'd7);
    sw_a(SW, 32'h18, 32'h0, 5'd7, 1'b0);
    ld_a(SW, 1'b0, 32'h18, 5'd8, 32'h55AA0000, 1'b0);
    sw_a(SW, 32'h14, 32'hDEADBEEF, 5'd0, 1'b0);
    alu_a(32'h12345678, 5'd0);
    sw_a(SW, 32'h14, 32'h0, 5'd0, 1'b0);
    ld_a(SW, 1'b0, 32'h14, 5'd9, 32'h0, 1'b0);
    sw_a(SW, 32'h440, 32'hA5A5A5A5, 5'd0, 1'b0);
    ld_a(SW, 1'b0, 32'h40, 5'd10, 32'hA5A5A5A5, 1'b0);
    sw_a(SH, 32'h42, 32'h0000BEEF, 5'd0, 1'b0);
    ld_a(SW, 1'b0, 32'h40, 5'd10, 32'hBEEFA5A5, 1'b0);
    idle_a();
    @(posedge clk);
    @(negedge clk);
    chk("a_idle_wbv", 64'(a_wbv), 64'd0);
    chk("a_idle_alu", 64'(a_walu), 64'd0);
    chk("a_idle_wreg", 64'(a_wwreg), 64'd0);
    @(posedge clk); #1;

    drv_b(1'b0, 1'b1, SD, 1'b0, 64'h20, 64'h0123456789ABCDEF,
          5'd0, 64'd0, 1'b0);
    drv_b(1'b1, 1'b0, SD, 1'b0, 64'h20, 64'd0, 5'd3,
          64'h0123456789ABCDEF, 1'b0);
    drv_b(1'b1, 1'b0, SW, 1'b0, 64'h24, 64'd0, 5'd4,
          64'h0000000001234567, 1'b0);
    drv_b(1'b1, 1'b0, SW, 1'b0, 64'h20, 64'd0, 5'd4,
          64'hFFFFFFFF89ABCDEF, 1'b0);
    drv_b(1'b1, 1'b0, SW, 1'b1, 64'h20, 64'd0, 5'd4,
          64'h0000000089ABCDEF, 1'b0);
    drv_b(1'b1, 1'b0, SD, 1'b0, 64'h24, 64'd0, 5'd5,
          64'd0, 1'b1);
    drv_b(1'b1, 1'b0, SH, 1'b1, 64'h26, 64'd0, 5'd5,
          64'h0000000000000123, 1'b0);
    drv_b(1'b0, 1'b1, SB, 1'b0, 64'h21, 64'h77, 5'd0,
          64'd0, 1'b0);

    b_valid = 1'b1; b_rd = 1'b1; b_wr = 1'b0; b_rw = 1'b1;
    b_m2r = 1'b1; b_size = SD; b_alu = 64'h20; b_wreg = 5'd9;
    @(posedge clk); #1;
    idle_b();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_stall", 64'(b_stall), 64'd0);
    chk("abort_wbv", 64'(b_wbv), 64'd0);
    chk("abort_rd", b_wrd, 64'd0);
    chk("abort_alu", b_walu, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_late", 64'(b_wbv), 64'd0);
    end
    @(posedge clk); #1;

    drv_b(1'b1, 1'b0, SD, 1'b0, 64'h20, 64'd0, 5'd6,
          64'h0123456789AB77EF, 1'b0);
    idle_b();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("a_drain", 64'(qa.size()), 64'd0);
    chk("b_drain", 64'(qb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
